// File: rtl/decode_stage.sv
// decode_stage: RV32I decode pipeline stage.
// Decodes the fetched instruction, reads the 32x32 register file, builds the
// sign-extended immediate and registers everything into the ID/EX register.
// It also flags load-use hazards back to fetch and emits a bubble for them.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instructionIn, PCIn instruction/PC pair from fetch
//   stall               downstream stall: hold ID/EX (regfile still writes)
//   flush               squash the instruction in decode
//   exMemRead, exRd     load in EX and its destination (hazard detection)
//   wbEn, wbRd, wbData  register file write port
//   hazardStall         combinational load-use stall toward fetch
//   PCOut .. illegal    registered ID/EX payload and control
//
// Optional feature: define DECODE_WB_BYPASS_EN to forward a same-cycle
// writeback to the register read ports.
module decode_stage #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] instructionIn,
  input  logic [width-1:0] PCIn,
  input  logic             stall,
  input  logic             flush,
  input  logic             exMemRead,
  input  logic [4:0]       exRd,
  input  logic             wbEn,
  input  logic [4:0]       wbRd,
  input  logic [width-1:0] wbData,
  output logic             hazardStall,
  output logic [width-1:0] PCOut,
  output logic [width-1:0] instructionOut,
  output logic [width-1:0] rs1Data,
  output logic [width-1:0] rs2Data,
  output logic [width-1:0] imm,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic             funct7b5,
  output logic             aluSrcImm,
  output logic             regWrite,
  output logic             memRead,
  output logic             memWrite,
  output logic             branch,
  output logic             jal,
  output logic             jalr,
  output logic             lui,
  output logic             auipc,
  output logic             illegal
);

  localparam int unsigned NUM_REGS = 32;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [width-1:0] pc;
    logic [width-1:0] instr;
    logic [width-1:0] rs1_data;
    logic [width-1:0] rs2_data;
    logic [width-1:0] imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             alu_src_imm;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             jal;
    logic             jalr;
    logic             lui;
    logic             auipc;
    logic             illegal;
  } id_ex_t;

  logic [width-1:0] rf [NUM_REGS];
  logic [31:0]      inst;
  logic [31:0]      imm32;
  logic             rs1_used;
  logic             rs2_used;
  logic             rd_wr;
  logic [width-1:0] rs1_val;
  logic [width-1:0] rs2_val;
  id_ex_t           dec;
  id_ex_t           dec_full;
  id_ex_t           bubble;
  id_ex_t           q;

  assign inst = instructionIn[31:0];

  // Opcode decode, operand-usage flags and immediate generation.
  always_comb begin
    dec          = '0;
    dec.pc       = PCIn;
    dec.instr    = instructionIn;
    rs1_used     = 1'b0;
    rs2_used     = 1'b0;
    rd_wr        = 1'b0;
    imm32        = '0;
    unique case (inst[6:0])
      OP_LUI: begin
        dec.lui = 1'b1; dec.alu_src_imm = 1'b1; rd_wr = 1'b1;
        imm32 = {inst[31:12], 12'b0};
      end
      OP_AUIPC: begin
        dec.auipc = 1'b1; dec.alu_src_imm = 1'b1; rd_wr = 1'b1;
        imm32 = {inst[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.jal = 1'b1; rd_wr = 1'b1;
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_JALR: begin
        dec.jalr = 1'b1; dec.alu_src_imm = 1'b1; rd_wr = 1'b1; rs1_used = 1'b1;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OP_BRANCH: begin
        dec.branch = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_LOAD: begin
        dec.mem_read = 1'b1; dec.alu_src_imm = 1'b1; rd_wr = 1'b1; rs1_used = 1'b1;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OP_STORE: begin
        dec.mem_write = 1'b1; dec.alu_src_imm = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_IMM: begin
        dec.alu_src_imm = 1'b1; rd_wr = 1'b1; rs1_used = 1'b1;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OP_OP: begin
        rd_wr = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (!dec.illegal) begin
      dec.funct3   = inst[14:12];
      dec.funct7b5 = inst[30];
    end
    // A write to x0 is architecturally a no-op, so it is not a write at all.
    dec.reg_write = rd_wr && (inst[11:7] != 5'd0);
    dec.rd        = dec.reg_write ? inst[11:7]  : 5'd0;
    dec.rs1       = rs1_used      ? inst[19:15] : 5'd0;
    dec.rs2       = rs2_used      ? inst[24:20] : 5'd0;
    dec.imm       = width'(imm32);
  end

  // Register file read; unused operands carry index 0 and therefore read 0.
  always_comb begin
    rs1_val = rf[dec.rs1];
    rs2_val = rf[dec.rs2];
`ifdef DECODE_WB_BYPASS_EN
    if (wbEn && (wbRd != 5'd0) && (wbRd == dec.rs1)) rs1_val = wbData;
    if (wbEn && (wbRd != 5'd0) && (wbRd == dec.rs2)) rs2_val = wbData;
`endif
    if (dec.rs1 == 5'd0) rs1_val = '0;
    if (dec.rs2 == 5'd0) rs2_val = '0;
  end

  always_comb begin
    dec_full          = dec;
    dec_full.rs1_data = rs1_val;
    dec_full.rs2_data = rs2_val;
  end

  // Bubble payload: a NOP with no control, carrying the incoming PC.
  always_comb begin
    bubble       = '0;
    bubble.instr = width'(NOP);
    bubble.pc    = PCIn;
  end

  // Unused operand indices are already 0, and exRd!=0 excludes x0 matches.
  assign hazardStall = !rst && !flush && exMemRead && (exRd != 5'd0) &&
                       ((exRd == dec.rs1) || (exRd == dec.rs2));

  // Register file write port; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wbEn && (wbRd != 5'd0)) begin
      rf[wbRd] <= wbData;
    end
  end

  // ID/EX register: reset > flush > stall (hold) > hazard bubble > decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= bubble;
      q.pc <= '0;
    end else if (flush) begin
      q <= bubble;
    end else if (!stall) begin
      q <= hazardStall ? bubble : dec_full;
    end
  end

  assign PCOut          = q.pc;
  assign instructionOut = q.instr;
  assign rs1Data        = q.rs1_data;
  assign rs2Data        = q.rs2_data;
  assign imm            = q.imm;
  assign rs1            = q.rs1;
  assign rs2            = q.rs2;
  assign rd             = q.rd;
  assign funct3         = q.funct3;
  assign funct7b5       = q.funct7b5;
  assign aluSrcImm      = q.alu_src_imm;
  assign regWrite       = q.reg_write;
  assign memRead        = q.mem_read;
  assign memWrite       = q.mem_write;
  assign branch         = q.branch;
  assign jal            = q.jal;
  assign jalr           = q.jalr;
  assign lui            = q.lui;
  assign auipc          = q.auipc;
  assign illegal        = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instructionIn, PCIn;
  logic        stall, flush, exMemRead;
  logic [4:0]  exRd;
  logic        wbEn;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
  logic        hazardStall;
  logic [31:0] PCOut, instructionOut, rs1Data, rs2Data, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic        funct7b5, aluSrcImm, regWrite, memRead, memWrite;
  logic        branch, jal, jalr, lui, auipc, illegal;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] I_ADDI   = 32'hFFF0_0093;  // addi x1,x0,-1
  localparam logic [31:0] I_ADD65  = 32'h0002_8333;  // add x6,x5,x0
  localparam logic [31:0] I_ADD432 = 32'h0021_8233;  // add x4,x3,x2
  localparam logic [31:0] I_BEQ    = 32'h0020_8463;  // beq x1,x2,+8
  localparam logic [31:0] I_ILL    = 32'h0000_007F;
  localparam logic [31:0] I_NOP    = 32'h0000_0013;

  always #5 clk = ~clk;

  decode_stage #(.width(32)) dut (
    .clk(clk), .rst(rst), .instructionIn(instructionIn), .PCIn(PCIn),
    .stall(stall), .flush(flush), .exMemRead(exMemRead), .exRd(exRd),
    .wbEn(wbEn), .wbRd(wbRd), .wbData(wbData), .hazardStall(hazardStall),
    .PCOut(PCOut), .instructionOut(instructionOut), .rs1Data(rs1Data),
    .rs2Data(rs2Data), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
    .funct3(funct3), .funct7b5(funct7b5), .aluSrcImm(aluSrcImm),
    .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .branch(branch), .jal(jal), .jalr(jalr), .lui(lui), .auipc(auipc),
    .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one active edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_bypass;
`ifdef DECODE_WB_BYPASS_EN
    exp_bypass = 32'h1234;
`else
    exp_bypass = 32'h0;
`endif
    rst = 1'b1; instructionIn = I_ADDI; PCIn = 32'h100; stall = 1'b0; flush = 1'b0;
    exMemRead = 1'b0; exRd = 5'd0; wbEn = 1'b0; wbRd = 5'd0; wbData = 32'h0;
    step(); step();
    check("rst_instr", instructionOut, I_NOP);
    check("rst_pc", PCOut, 32'h0);
    check("rst_regwrite", 32'(regWrite), 32'h0);
    check("rst_alusrc", 32'(aluSrcImm), 32'h0);
    check("rst_imm", imm, 32'h0);
    check("rst_rd", 32'(rd), 32'h0);
    check("rst_hazard_gated", 32'(hazardStall), 32'h0);
    rst = 1'b0;

    // Every register x1..x31 must read 0 after reset (add x0,xi,xi).
    for (int i = 1; i < 32; i++) begin
      instructionIn = (32'(i) << 20) | (32'(i) << 15) | 32'h33;
      step();
      check($sformatf("rst_x%0d_rs1", i), rs1Data, 32'h0);
      check($sformatf("rst_x%0d_rs2", i), rs2Data, 32'h0);
    end
    check("add_x0_regwrite", 32'(regWrite), 32'h0);

    // ADDI decode.
    instructionIn = I_ADDI; PCIn = 32'h40;
    step();
    check("addi_imm", imm, 32'hFFFF_FFFF);
    check("addi_rd", 32'(rd), 32'd1);
    check("addi_regwrite", 32'(regWrite), 32'h1);
    check("addi_alusrc", 32'(aluSrcImm), 32'h1);
    check("addi_pc", PCOut, 32'h40);
    check("addi_rs2", 32'(rs2), 32'h0);
    check("addi_instr", instructionOut, I_ADDI);

    // Same-cycle writeback of x5 while decoding add x6,x5,x0.
    wbEn = 1'b1; wbRd = 5'd5; wbData = 32'h1234; instructionIn = I_ADD65; PCIn = 32'h44;
    step();
    check("wb_same_cycle_rs1", rs1Data, exp_bypass);
    check("wb_add_rd", 32'(rd), 32'd6);
    check("wb_add_rs1", 32'(rs1), 32'd5);
    check("wb_add_alusrc", 32'(aluSrcImm), 32'h0);
    check("wb_add_imm", imm, 32'h0);
    wbEn = 1'b0;
    step();
    check("wb_committed_rs1", rs1Data, 32'h1234);

    // Load-use hazard on rs1.
    exMemRead = 1'b1; exRd = 5'd3; instructionIn = I_ADD432; PCIn = 32'h48;
    #1;
    check("lu_hazard", 32'(hazardStall), 32'h1);
    step();
    check("lu_bubble_instr", instructionOut, I_NOP);
    check("lu_bubble_regwrite", 32'(regWrite), 32'h0);
    check("lu_bubble_rd", 32'(rd), 32'h0);
    check("lu_bubble_pc", PCOut, 32'h48);
    exMemRead = 1'b0;
    #1;
    check("lu_released", 32'(hazardStall), 32'h0);
    step();
    check("lu_issue_instr", instructionOut, I_ADD432);
    check("lu_issue_rd", 32'(rd), 32'd4);
    check("lu_issue_rs2", 32'(rs2), 32'd2);
    exMemRead = 1'b1; exRd = 5'd0;
    #1;
    check("lu_exrd0", 32'(hazardStall), 32'h0);
    exRd = 5'd7;
    #1;
    check("lu_nomatch", 32'(hazardStall), 32'h0);
    exRd = 5'd2;
    #1;
    check("lu_rs2_match", 32'(hazardStall), 32'h1);

    // Flush beats stall and masks the hazard.
    exRd = 5'd1; instructionIn = I_BEQ; PCIn = 32'h50; flush = 1'b1; stall = 1'b1;
    #1;
    check("flush_hazard_gated", 32'(hazardStall), 32'h0);
    step();
    check("flush_instr", instructionOut, I_NOP);
    check("flush_branch", 32'(branch), 32'h0);
    flush = 1'b0; stall = 1'b0; exMemRead = 1'b0;
    step();
    check("beq_branch", 32'(branch), 32'h1);
    check("beq_imm", imm, 32'h8);
    check("beq_rd", 32'(rd), 32'h0);
    check("beq_regwrite", 32'(regWrite), 32'h0);
    check("beq_rs1", 32'(rs1), 32'd1);
    check("beq_rs2", 32'(rs2), 32'd2);

    // Downstream stall holds the register.
    stall = 1'b1; instructionIn = I_ADDI; PCIn = 32'h54;
    step();
    check("stall_hold_instr", instructionOut, I_BEQ);
    check("stall_hold_pc", PCOut, 32'h50);
    stall = 1'b0;

    // Illegal opcode.
    instructionIn = I_ILL; PCIn = 32'h58;
    step();
    check("ill_illegal", 32'(illegal), 32'h1);
    check("ill_regwrite", 32'(regWrite), 32'h0);
    check("ill_alusrc", 32'(aluSrcImm), 32'h0);
    check("ill_memread", 32'(memRead), 32'h0);

    // Writes to x0 are dropped.
    wbEn = 1'b1; wbRd = 5'd0; wbData = 32'hDEAD; instructionIn = 32'h0000_0033; // add x0,x0,x0
    step();
    wbEn = 1'b0;
    step();
    check("x0_rs1", rs1Data, 32'h0);
    check("x0_rs2", rs2Data, 32'h0);

    // Reset during a hazard: hazard masked, PC zeroed, regfile cleared.
    exMemRead = 1'b1; exRd = 5'd3; instructionIn = I_ADD432; PCIn = 32'h60; rst = 1'b1;
    #1;
    check("rst_mid_hazard", 32'(hazardStall), 32'h0);
    step();
    check("rst_mid_pc", PCOut, 32'h0);
    check("rst_mid_instr", instructionOut, I_NOP);
    rst = 1'b0; exMemRead = 1'b0; instructionIn = I_ADD65; PCIn = 32'h64;
    step();
    check("rst_cleared_x5", rs1Data, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second stage of the in-order RV32I pipeline. Consumes the instruction/PC pair from the fetch stage, decodes it, reads the 32×32 register file and generates the immediate. Registers the results into the ID/EX pipeline register. Detects load-use hazards and asserts a stall back to fetch, inserting a bubble toward execute.

## Interface
- `width`, 32: datapath and PC width.
- `clk` in 1: clock, all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `instructionIn` in width: instruction from fetch (`0x00000013` = NOP).
- `PCIn` in width: PC of `instructionIn`.
- `stall` in 1: downstream stall; hold all outputs and state except regfile writes.
- `flush` in 1: squash the instruction currently in decode (branch/jump redirect).
- `exMemRead` in 1: instruction currently in EX is a load.
- `exRd` in 5: destination of the instruction in EX.
- `wbEn` in 1: writeback enable.
- `wbRd` in 5: writeback register index.
- `wbData` in width: writeback data.
- `hazardStall` out 1: combinational; load-use detected, fetch must hold.
- `PCOut` out width: registered PC.
- `instructionOut` out width: registered instruction (for debug/trace).
- `rs1Data`, `rs2Data` out width: registered operand values.
- `imm` out width: registered sign-extended immediate.
- `rs1`, `rs2`, `rd` out 5: registered register indices, forced to 0 when unused.
- `funct3` out 3; `funct7b5` out 1: registered ALU selectors.
- `aluSrcImm`, `regWrite`, `memRead`, `memWrite`, `branch`, `jal`, `jalr`, `lui`, `auipc`, `illegal` out 1: registered control.

## Operation
- Opcodes decoded: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011. Any other opcode sets `illegal=1` and clears all other control bits.
- Immediates are sign-extended from bit 31 (I, S, B, U, J formats). B/J set bit 0 to 0. U is `{inst[31:12],12'b0}`. R-type yields `imm=0`.
- rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP. rs2 is used by BRANCH, STORE, OP. `rd` is nonzero only when `regWrite=1`. `rd=0` forces `regWrite=0`.
- Register file: 32 entries; x0 always reads 0, and writes to x0 are ignored. A write on posedge with `wbEn` commits `wbData`.
- `hazardStall = exMemRead && exRd!=0 && ((rs1 used && exRd==rs1) || (rs2 used && exRd==rs2))`. It is gated off by `flush`.
- Register update priority per posedge:
  1. `rst`: all outputs go to their bubble values, the regfile is cleared, and `PCOut=0`.
  2. `flush`: outputs load a bubble.
  3. `stall`: hold.
  4. `hazardStall`: load a bubble.
  5. Otherwise: load the decoded instruction.
- Bubble values: `instructionOut=0x13`, all control bits 0, indices 0, data/imm 0. `PCOut` takes `PCIn`; on reset `PCOut=0`.
- Regfile writes occur regardless of `stall`/`flush`/hazard (not during `rst`).

## Timing
- Decode-to-output latency: 1 cycle. `instructionIn` sampled at edge N appears on the outputs after edge N.
- `hazardStall` is combinational from `instructionIn`, `exMemRead` and `exRd` in the same cycle. Fetch holds its output during this cycle. One bubble is emitted, and on the next cycle the load has left EX, so the stall drops.
- Same-cycle writeback and read of the same nonzero register returns `wbData` (see Configuration).
- `stall` together with `flush`: `flush` wins.
- `rst` mid-stall/hazard: reset wins, and `hazardStall` has no effect while `rst=1`.

## Configuration
- `DECODE_WB_BYPASS_EN` defined: a read matching a same-cycle `wbEn && wbRd!=0` write returns `wbData`.
- Not defined: the read returns the pre-write regfile value. The hazard unit elsewhere must then cover the WB→ID gap. `hazardStall` logic is unchanged.

## Test plan
- Reset: hold `rst` 2 cycles → `instructionOut=0x13`, `PCOut=0`, all control 0, and x1..x31 read 0 afterward.
- ADDI decode: `instructionIn=0xFFF00093` (addi x1,x0,-1), `PCIn=0x40` → next cycle `imm=0xFFFFFFFF`, `rd=1`, `regWrite=1`, `aluSrcImm=1`, `PCOut=0x40`.
- Writeback/bypass: `wbEn=1`, `wbRd=5`, `wbData=0x1234` and same-cycle decode of `add x6,x5,x0` → `rs1Data=0x1234` with macro; `0` without macro (after reset).
- Load-use: `exMemRead=1`, `exRd=3`, decode `add x4,x3,x2` → `hazardStall=1` that cycle and a bubble output. With `exRd=0` or `exMemRead=0` → no stall.
- Flush priority: `flush=1`, `stall=1`, valid BRANCH → bubble output and `hazardStall=0`.
- Illegal/x0: opcode `0x7F` → `illegal=1`, other control 0. Write x0 with `0xDEAD` → x0 still reads 0.
